// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the WB stage
// (fixed priority) and a multi-cycle unit behind a one-entry skid buffer, and
// keeps a per-register busy scoreboard for outstanding MU destinations.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int REG_N      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [$clog2(REG_N)-1:0] wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mu_valid,
  output logic                     mu_ready,
  input  logic [$clog2(REG_N)-1:0] mu_rd,
  input  logic [DATA_W-1:0]        mu_data,
  input  logic                     iss_valid,
  input  logic [$clog2(REG_N)-1:0] iss_rd,
  input  logic [$clog2(REG_N)-1:0] chk_rs1,
  input  logic [$clog2(REG_N)-1:0] chk_rs2,
  input  logic [$clog2(REG_N)-1:0] chk_rd,
  output logic                     hazard,
  output logic                     wb_hold,
  output logic                     rf_we,
  output logic [$clog2(REG_N)-1:0] rf_rd,
  output logic [DATA_W-1:0]        rf_wdata
);

  localparam int AW = $clog2(REG_N);

  logic              buf_full;
  logic [AW-1:0]     buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic [REG_N-1:0]  busy;
  logic [REG_N-1:0]  busy_nx;
  logic              accept;
  logic              wb_win;
  logic              buf_grant;
  logic              buf_drop;

  assign mu_ready  = ~buf_full;
  assign accept    = mu_valid & ~buf_full;
  assign wb_win    = wb_valid & (wb_rd != '0) & ~wb_hold;
  // An x0 entry never uses the port, so it is dropped regardless of WB.
  assign buf_drop  = buf_full & (buf_rd == '0);
  assign buf_grant = buf_full & (buf_rd != '0) & ~wb_win;
  assign hazard    = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign wb_hold = buf_full & (buf_rd != '0) & (starve_cnt == CW'(STARVE_MAX));

  // Saturating count of cycles the buffered entry has been denied the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (~buf_full || buf_drop || buf_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_starve;

  assign wb_hold       = 1'b0;
  assign unused_starve = (STARVE_MAX != 0);
`endif

  // Skid buffer: load on accept, empty on grant or x0 drop (never both at once).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_rd   <= '0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_rd   <= mu_rd;
      buf_data <= mu_data;
    end else if (buf_grant || buf_drop) begin
      buf_full <= 1'b0;
    end
  end

  // Scoreboard update; the set is applied last so it wins a same-register clear.
  always_comb begin
    busy_nx = busy;
    if (buf_grant) begin
      busy_nx[buf_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_nx[iss_rd] = 1'b1;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nx;
    end
  end

  // Registered write port; address/data hold when no grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (wb_win) begin
      rf_we    <= 1'b1;
      rf_rd    <= wb_rd;
      rf_wdata <= wb_data;
    end else if (buf_grant) begin
      rf_we    <= 1'b1;
      rf_rd    <= buf_rd;
      rf_wdata <= buf_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        mu_valid;
  logic        mu_ready;
  logic [4:0]  mu_rd;
  logic [63:0] mu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.DATA_W(64), .REG_N(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_rd(mu_rd), .mu_data(mu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mu_valid = 0; mu_rd = 0; mu_data = 0;
    iss_valid = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic test_reset();
    logic [69:0] got;
    idle();
    reset = 1'b1;
    #1;
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== 70'd0) begin errors++; $display("FAIL reset_port got=%h exp=0", got); end
    checks++; if ({mu_ready, hazard, wb_hold} !== 3'b100) begin errors++; $display("FAIL reset_flags got=%b exp=100", {mu_ready, hazard, wb_hold}); end
    tick();
    reset = 1'b0;
    // Mid-operation reset: busy[7] set, buffer holding x7, WB write in flight.
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    mu_valid = 1; mu_rd = 7; mu_data = 64'h77;
    wb_valid = 1; wb_rd = 1; wb_data = 64'h5;
    tick();
    mu_valid = 0; chk_rs1 = 7;
    #1;
    checks++; if ({rf_we, mu_ready, hazard} !== 3'b101) begin errors++; $display("FAIL prereset_state got=%b exp=101", {rf_we, mu_ready, hazard}); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({rf_we, mu_ready, hazard, wb_hold} !== 4'b0100) begin errors++; $display("FAIL async_reset got=%b exp=0100", {rf_we, mu_ready, hazard, wb_hold}); end
    checks++; if ({rf_rd, rf_wdata} !== 69'd0) begin errors++; $display("FAIL async_reset_addr got=%h exp=0", {rf_rd, rf_wdata}); end
    tick();
    #2;
    reset = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lost_entry_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_idle_port();
    logic [69:0] got;
    idle();
    iss_valid = 1; iss_rd = 5;
    tick();
    iss_valid = 0; chk_rs1 = 5;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL idle_hazard_set got=%b exp=1", hazard); end
    mu_valid = 1; mu_rd = 5; mu_data = 64'hAB;
    tick();
    mu_valid = 0;
    checks++; if ({rf_we, mu_ready} !== 2'b00) begin errors++; $display("FAIL idle_accept got=%b exp=00", {rf_we, mu_ready}); end
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd5, 64'hAB}) begin errors++; $display("FAIL idle_write got=%h exp=%h", got, {1'b1, 5'd5, 64'hAB}); end
    checks++; if ({hazard, mu_ready} !== 2'b01) begin errors++; $display("FAIL idle_clear got=%b exp=01", {hazard, mu_ready}); end
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b0, 5'd5, 64'hAB}) begin errors++; $display("FAIL idle_hold got=%h exp=%h", got, {1'b0, 5'd5, 64'hAB}); end
  endtask

  task automatic test_contention();
    logic [69:0] got;
    idle();
    mu_valid = 1; mu_rd = 3; mu_data = 64'h11;
    tick();
    mu_valid = 0;
    wb_valid = 1; wb_rd = 9; wb_data = 64'h22;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {rf_we, rf_rd, rf_wdata};
      checks++; if (got !== {1'b1, 5'd9, 64'h22}) begin errors++; $display("FAIL cont_wb%0d got=%h exp=%h", i, got, {1'b1, 5'd9, 64'h22}); end
      checks++; if (mu_ready !== 1'b0) begin errors++; $display("FAIL cont_ready%0d got=%b exp=0", i, mu_ready); end
    end
    wb_valid = 0;
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd3, 64'h11}) begin errors++; $display("FAIL cont_mu got=%h exp=%h", got, {1'b1, 5'd3, 64'h11}); end
    checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL cont_ready_after got=%b exp=1", mu_ready); end
  endtask

  task automatic test_x0();
    logic [69:0] got;
    idle();
    wb_valid = 1; wb_rd = 0; wb_data = 64'hFF;
    tick();
    wb_valid = 0;
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b0, 5'd3, 64'h11}) begin errors++; $display("FAIL x0_wb got=%h exp=%h", got, {1'b0, 5'd3, 64'h11}); end
    mu_valid = 1; mu_rd = 0; mu_data = 64'h99;
    tick();
    mu_valid = 0;
    tick();
    checks++; if ({rf_we, mu_ready} !== 2'b01) begin errors++; $display("FAIL x0_mu got=%b exp=01", {rf_we, mu_ready}); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_mu_late got=%b exp=0", rf_we); end
    iss_valid = 1; iss_rd = 0;
    tick();
    iss_valid = 0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL x0_busy got=%b exp=0", hazard); end
  endtask

  task automatic test_collision();
    logic [69:0] got;
    idle();
    iss_valid = 1; iss_rd = 4;
    tick();
    iss_valid = 0;
    mu_valid = 1; mu_rd = 4; mu_data = 64'h44;
    tick();
    mu_valid = 0;
    iss_valid = 1; iss_rd = 4;
    tick();
    iss_valid = 0;
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd4, 64'h44}) begin errors++; $display("FAIL coll_write got=%h exp=%h", got, {1'b1, 5'd4, 64'h44}); end
    chk_rd = 4;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_hazard_rd got=%b exp=1", hazard); end
    chk_rd = 0; chk_rs2 = 4;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_hazard_rs2 got=%b exp=1", hazard); end
    chk_rs2 = 0;
  endtask

  task automatic test_starve();
    logic [69:0] got;
    idle();
    mu_valid = 1; mu_rd = 6; mu_data = 64'h66;
    tick();
    mu_valid = 0;
    wb_valid = 1; wb_rd = 10; wb_data = 64'hA0;
    #1;
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 1; i <= 4; i++) begin
      checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL starve_nohold%0d got=%b exp=0", i, wb_hold); end
      tick();
      got = {rf_we, rf_rd, rf_wdata};
      checks++; if (got !== {1'b1, 5'd10, 64'hA0}) begin errors++; $display("FAIL starve_wb%0d got=%h exp=%h", i, got, {1'b1, 5'd10, 64'hA0}); end
    end
    checks++; if ({wb_hold, mu_ready} !== 2'b10) begin errors++; $display("FAIL starve_hold got=%b exp=10", {wb_hold, mu_ready}); end
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd6, 64'h66}) begin errors++; $display("FAIL starve_mu got=%h exp=%h", got, {1'b1, 5'd6, 64'h66}); end
    checks++; if ({wb_hold, mu_ready} !== 2'b01) begin errors++; $display("FAIL starve_after got=%b exp=01", {wb_hold, mu_ready}); end
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd10, 64'hA0}) begin errors++; $display("FAIL starve_resume got=%h exp=%h", got, {1'b1, 5'd10, 64'hA0}); end
`else
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {rf_we, rf_rd, rf_wdata};
      if (got !== {1'b1, 5'd10, 64'hA0} || wb_hold !== 1'b0 || mu_ready !== 1'b0) begin
        errors++;
        $display("FAIL starve_wb%0d got=%h hold=%b ready=%b exp=%h hold=0 ready=0", i, got, wb_hold, mu_ready, {1'b1, 5'd10, 64'hA0});
      end
      checks++;
    end
    wb_valid = 0;
    tick();
    got = {rf_we, rf_rd, rf_wdata};
    checks++; if (got !== {1'b1, 5'd6, 64'h66}) begin errors++; $display("FAIL starve_mu got=%h exp=%h", got, {1'b1, 5'd6, 64'h66}); end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_idle_port();
    test_contention();
    test_x0();
    test_collision();
    test_starve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (WB) stage and a long-latency multi-cycle unit (MU, e.g. mul/div).
- WB has fixed priority.
- MU results wait in a one-entry skid buffer until the port is free.
- A per-register busy scoreboard tracks outstanding MU destinations so the issue stage can stall on RAW and WAW hazards.
- Sits between the WB/MU outputs and the register file write inputs (regWrite/rd/writeData).

Parameters:
DATA_W, 64, write data width
REG_N, 32, number of architectural registers (index width 5)
STARVE_MAX, 4, consecutive denied cycles before the starvation guard fires (only with the optional feature)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
wb_valid  in  1  WB stage has a register write this cycle
wb_rd  in  5  WB destination register
wb_data  in  DATA_W  WB write data
mu_valid  in  1  MU result valid
mu_ready  out  1  skid buffer can accept (combinational: buffer empty)
mu_rd  in  5  MU destination register
mu_data  in  DATA_W  MU result
iss_valid  in  1  issue stage dispatches an MU operation this cycle
iss_rd  in  5  destination of the dispatched MU operation
chk_rs1  in  5  issue-stage source 1
chk_rs2  in  5  issue-stage source 2
chk_rd  in  5  issue-stage destination
hazard  out  1  combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]
wb_hold  out  1  WB must freeze this cycle (starvation guard only; otherwise 0)
rf_we  out  1  register file regWrite
rf_rd  out  5  register file rd
rf_wdata  out  DATA_W  register file writeData

Behaviour:
- Reset (asynchronous, any time):
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - Buffer empty, so mu_ready=1.
  - All busy bits 0, starvation counter 0, wb_hold=0.
  - A write in flight at reset is lost.
- Register x0: a request with rd==0 is treated as no request. It never drives rf_we=1, never sets a busy bit, and a buffered x0 entry is discarded (buffer emptied) without a write.
- Acceptance: when mu_valid & mu_ready, {mu_rd, mu_data} is loaded into the buffer.
- The buffer is never written directly from mu_* to the port. Minimum MU-to-write latency is 2 cycles: accept, then grant.
- Grant, evaluated each cycle:
  - If wb_valid & wb_rd!=0 and wb_hold=0: WB wins.
  - Else if the buffer is full: the buffer wins and empties.
  - Else: no grant.
- Outputs are registered. rf_we/rf_rd/rf_wdata reflect the grant on the next rising edge and hold for exactly one cycle. With no grant, rf_we=0 and rf_rd/rf_wdata hold their last values.
- Simultaneous buffer drain and new accept in the same cycle is not possible, because mu_ready depends on the empty flag at cycle start.
- Scoreboard:
  - iss_valid & iss_rd!=0 sets busy[iss_rd].
  - A buffer grant clears busy[buffered rd].
  - If set and clear hit the same register in the same cycle, the set wins.
  - busy bits do not track WB writes. The issue stage must stall on hazard, which guarantees no WB write to a busy register, so ordering is preserved.
- hazard is purely combinational from the current busy vector. It does not see a same-cycle iss_valid.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A saturating counter increments each cycle the buffer is full and not granted, and resets to 0 on a buffer grant or when the buffer is empty.
  - When the counter reaches STARVE_MAX, wb_hold=1 for one cycle and the buffer wins regardless of wb_valid. The pipeline must keep the WB request stable that cycle.
- Undefined: no counter logic exists, wb_hold is tied to 0, and WB priority is absolute.

Test Plan:
1. Reset mid-operation: buffer full with x7, busy[7]=1, assert reset → same cycle rf_we=0, mu_ready=1, hazard=0 for chk_rs1=7.
2. Idle port: MU issue x5 (busy[5]=1, hazard=1 for chk_rs1=5), then mu_valid rd=5 data=0xAB with wb_valid=0 → accepted at cycle t, rf_we=1 rf_rd=5 rf_wdata=0xAB at edge t+2, busy[5] cleared, hazard=0.
3. Contention: buffer holds x3=0x11, wb_valid rd=9 data=0x22 for 2 cycles, then idle → writes in order x9=0x22, x9=0x22, x3=0x11. mu_ready=0 until x3 is granted.
4. x0 filtering: wb_valid rd=0 data=0xFF alone → rf_we stays 0. mu_valid rd=0 → accepted, no write, buffer empties, mu_ready=1 next cycle. iss_rd=0 → busy unchanged.
5. Scoreboard collision: buffered x4 granted in the same cycle as iss_valid iss_rd=4 → busy[4]=1 afterwards, hazard=1 for chk_rd=4.
6. ARB_STARVE_GUARD_EN, STARVE_MAX=4: buffer full, wb_valid held high continuously → wb_hold=1 on the 5th cycle, the buffer entry is written on the next edge, the counter returns to 0, and WB resumes. With the macro undefined, the buffer is never written while wb_valid stays high.
